// File: rtl/falling_piece_controller_pkg.sv
// Shared types and geometry constants for the falling-piece controller.
// Pixel coordinates are unsigned 10-bit; every move is one square edge.
package tetris_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t SQ_SIZE = 10'd20;
    localparam coord_t FLOOR_Y = 10'd460;
    localparam coord_t X_MIN   = 10'd200;
    localparam coord_t X_MAX   = 10'd380;

    typedef enum logic [1:0] {
        WAIT_SPAWN,
        FALL,
        LANDED
    } piece_state_t;

endpackage

// File: rtl/falling_piece_controller_if.sv
// Spawn/gravity/move bundle between the shape generator, board and piece controller.
// Carries hard_drop only when HARD_DROP_EN is defined.
interface falling_piece_controller_if;

    logic                coord;
    tetris_pkg::coord_t  new_square_1x, new_square_1y, new_square_2x, new_square_2y;
    tetris_pkg::coord_t  new_square_3x, new_square_3y, new_square_4x, new_square_4y;
    logic                drop_tick;
    logic                move_left;
    logic                move_right;
    logic [3:0]          blocked_below;
    logic [3:0]          blocked_left;
    logic [3:0]          blocked_right;
`ifdef HARD_DROP_EN
    logic                hard_drop;
`endif
    tetris_pkg::coord_t  sq1x, sq1y, sq2x, sq2y, sq3x, sq3y, sq4x, sq4y;
    logic                active;
    logic                at_bottom, at_bottom2, at_bottom3, at_bottom4;
    logic                lock_pulse;

    modport slave (
`ifdef HARD_DROP_EN
        input  hard_drop,
`endif
        input  coord,
        input  new_square_1x, new_square_1y, new_square_2x, new_square_2y,
        input  new_square_3x, new_square_3y, new_square_4x, new_square_4y,
        input  drop_tick, move_left, move_right,
        input  blocked_below, blocked_left, blocked_right,
        output sq1x, sq1y, sq2x, sq2y, sq3x, sq3y, sq4x, sq4y,
        output active, at_bottom, at_bottom2, at_bottom3, at_bottom4, lock_pulse
    );

    modport master (
`ifdef HARD_DROP_EN
        output hard_drop,
`endif
        output coord,
        output new_square_1x, new_square_1y, new_square_2x, new_square_2y,
        output new_square_3x, new_square_3y, new_square_4x, new_square_4y,
        output drop_tick, move_left, move_right,
        output blocked_below, blocked_left, blocked_right,
        input  sq1x, sq1y, sq2x, sq2y, sq3x, sq3y, sq4x, sq4y,
        input  active, at_bottom, at_bottom2, at_bottom3, at_bottom4, lock_pulse
    );

endinterface

// File: rtl/piece_move_check.sv
// Combinational legality checks for the current piece: sideways moves and landing.
module piece_move_check #(
    parameter tetris_pkg::coord_t FLOOR_Y = tetris_pkg::FLOOR_Y,
    parameter tetris_pkg::coord_t X_MIN   = tetris_pkg::X_MIN,
    parameter tetris_pkg::coord_t X_MAX   = tetris_pkg::X_MAX
) (
    input  tetris_pkg::coord_t [3:0] sq_x_i,
    input  tetris_pkg::coord_t [3:0] sq_y_i,
    input  logic [3:0]               blocked_below_i,
    input  logic [3:0]               blocked_left_i,
    input  logic [3:0]               blocked_right_i,
    output logic                     can_left_o,
    output logic                     can_right_o,
    output logic [3:0]               land_o
);

    always_comb begin
        can_left_o  = (blocked_left_i == 4'b0000);
        can_right_o = (blocked_right_i == 4'b0000);
        land_o      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sq_x_i[i] <= X_MIN) can_left_o = 1'b0;
            if (sq_x_i[i] >= X_MAX) can_right_o = 1'b0;
            land_o[i] = (sq_y_i[i] == FLOOR_Y) | blocked_below_i[i];
        end
    end

endmodule

// File: rtl/falling_piece_controller.sv
// Falling-piece FSM: latches a spawned piece, applies gravity and moves, flags landing.
// Optional HARD_DROP_EN adds a latched hard-drop mode that descends every cycle.
module falling_piece_controller #(
    parameter tetris_pkg::coord_t SQ      = tetris_pkg::SQ_SIZE,
    parameter tetris_pkg::coord_t FLOOR_Y = tetris_pkg::FLOOR_Y,
    parameter tetris_pkg::coord_t X_MIN   = tetris_pkg::X_MIN,
    parameter tetris_pkg::coord_t X_MAX   = tetris_pkg::X_MAX
) (
    input logic                        Clk,
    input logic                        Reset,
    falling_piece_controller_if.slave  bus
);

    import tetris_pkg::*;

    piece_state_t state_q, state_d;
    coord_t [3:0] x_q, x_d, y_q, y_d;
    coord_t [3:0] new_x, new_y;
    logic   [3:0] ab_q, ab_d;
    logic         lock_q, lock_d;
    logic         active;
    logic         can_left, can_right;
    logic   [3:0] land;
    logic         tick, moves_en;

    assign new_x = {bus.new_square_4x, bus.new_square_3x, bus.new_square_2x, bus.new_square_1x};
    assign new_y = {bus.new_square_4y, bus.new_square_3y, bus.new_square_2y, bus.new_square_1y};

    piece_move_check #(
        .FLOOR_Y (FLOOR_Y),
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX)
    ) u_check (
        .sq_x_i          (x_q),
        .sq_y_i          (y_q),
        .blocked_below_i (bus.blocked_below),
        .blocked_left_i  (bus.blocked_left),
        .blocked_right_i (bus.blocked_right),
        .can_left_o      (can_left),
        .can_right_o     (can_right),
        .land_o          (land)
    );

`ifdef HARD_DROP_EN
    logic hd_q, hd_d;
    // Once latched, the hard-drop flag stands in for drop_tick and locks out moves.
    assign tick     = bus.drop_tick | hd_q;
    assign moves_en = ~hd_q;
`else
    assign tick     = bus.drop_tick;
    assign moves_en = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= WAIT_SPAWN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.coord)                                   state_d = FALL;
        else if (state_q == FALL && tick && (|land))     state_d = LANDED;
    end

    always_comb begin
        active = (state_q == FALL);
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        ab_d   = ab_q;
        lock_d = 1'b0;
`ifdef HARD_DROP_EN
        hd_d   = hd_q;
`endif
        if (bus.coord) begin
            x_d  = new_x;
            y_d  = new_y;
            ab_d = '0;
`ifdef HARD_DROP_EN
            hd_d = 1'b0;
`endif
        end else if (state_q == FALL) begin
`ifdef HARD_DROP_EN
            if (bus.hard_drop) hd_d = 1'b1;
`endif
            if (tick) begin
                if (|land) begin
                    ab_d   = land;
                    lock_d = 1'b1;
`ifdef HARD_DROP_EN
                    hd_d   = 1'b0;
`endif
                end else begin
                    for (int unsigned i = 0; i < 4; i++) y_d[i] = y_q[i] + SQ;
                end
            end else if (moves_en && (bus.move_left ^ bus.move_right)) begin
                if (bus.move_left && can_left) begin
                    for (int unsigned i = 0; i < 4; i++) x_d[i] = x_q[i] - SQ;
                end else if (bus.move_right && can_right) begin
                    for (int unsigned i = 0; i < 4; i++) x_d[i] = x_q[i] + SQ;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            ab_q   <= '0;
            lock_q <= 1'b0;
`ifdef HARD_DROP_EN
            hd_q   <= 1'b0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            ab_q   <= ab_d;
            lock_q <= lock_d;
`ifdef HARD_DROP_EN
            hd_q   <= hd_d;
`endif
        end
    end

    assign bus.sq1x       = x_q[0];
    assign bus.sq1y       = y_q[0];
    assign bus.sq2x       = x_q[1];
    assign bus.sq2y       = y_q[1];
    assign bus.sq3x       = x_q[2];
    assign bus.sq3y       = y_q[2];
    assign bus.sq4x       = x_q[3];
    assign bus.sq4y       = y_q[3];
    assign bus.at_bottom  = ab_q[0];
    assign bus.at_bottom2 = ab_q[1];
    assign bus.at_bottom3 = ab_q[2];
    assign bus.at_bottom4 = ab_q[3];
    assign bus.lock_pulse = lock_q;
    assign bus.active     = active;

endmodule

// File: tb/tb_falling_piece_controller.sv
// Directed and random checks of falling_piece_controller against a pixel-level piece model.
// Exercises the hard-drop path only when HARD_DROP_EN is defined.
module tb_falling_piece_controller;

    logic Clk = 1'b0;
    logic Reset;
    falling_piece_controller_if bus ();

    falling_piece_controller #(
        .SQ      (10'd20),
        .FLOOR_Y (10'd460),
        .X_MIN   (10'd200),
        .X_MAX   (10'd380)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference piece: pixel positions, phase (0 waiting, 1 falling, 2 landed), flags.
    int       mx[4], my[4];
    int       mst;
    bit [3:0] mab;
    bit       mlock;
    bit       mflag;
    int       sx[4], sy[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dut_x(input int i);
        case (i)
            0: return bus.sq1x;
            1: return bus.sq2x;
            2: return bus.sq3x;
            default: return bus.sq4x;
        endcase
    endfunction

    function automatic logic [9:0] dut_y(input int i);
        case (i)
            0: return bus.sq1y;
            1: return bus.sq2y;
            2: return bus.sq3y;
            default: return bus.sq4y;
        endcase
    endfunction

    task automatic set_spawn(input int x0, y0, x1, y1, x2, y2, x3, y3);
        sx[0] = x0; sy[0] = y0; sx[1] = x1; sy[1] = y1;
        sx[2] = x2; sy[2] = y2; sx[3] = x3; sy[3] = y3;
        bus.new_square_1x = 10'(x0); bus.new_square_1y = 10'(y0);
        bus.new_square_2x = 10'(x1); bus.new_square_2y = 10'(y1);
        bus.new_square_3x = 10'(x2); bus.new_square_3y = 10'(y2);
        bus.new_square_4x = 10'(x3); bus.new_square_4y = 10'(y3);
    endtask

    function automatic void model_step();
        bit hd, tick, ok;
        bit [3:0] lb;
        hd = 1'b0;
`ifdef HARD_DROP_EN
        hd = bus.hard_drop;
`endif
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin mx[i] = 0; my[i] = 0; end
            mab = '0; mlock = 0; mst = 0; mflag = 0;
        end else begin
            mlock = 0;
            if (bus.coord) begin
                for (int i = 0; i < 4; i++) begin mx[i] = sx[i]; my[i] = sy[i]; end
                mab = '0; mst = 1; mflag = 0;
            end else if (mst == 1) begin
                tick = bus.drop_tick || mflag;
                ok   = !mflag;
                if (hd) mflag = 1;
                if (tick) begin
                    for (int i = 0; i < 4; i++) lb[i] = (my[i] == 460) || bus.blocked_below[i];
                    if (lb != 0) begin
                        mab = lb; mlock = 1; mst = 2; mflag = 0;
                    end else begin
                        for (int i = 0; i < 4; i++) my[i] += 20;
                    end
                end else if (ok && bus.move_left != bus.move_right) begin
                    if (bus.move_left) begin
                        ok = (bus.blocked_left == 0);
                        for (int i = 0; i < 4; i++) if (mx[i] <= 200) ok = 0;
                        if (ok) for (int i = 0; i < 4; i++) mx[i] -= 20;
                    end else begin
                        ok = (bus.blocked_right == 0);
                        for (int i = 0; i < 4; i++) if (mx[i] >= 380) ok = 0;
                        if (ok) for (int i = 0; i < 4; i++) mx[i] += 20;
                    end
                end
            end
        end
    endfunction

    // Advance one clock with the currently driven inputs, then compare everything.
    task automatic cycle(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.sq%0dx", tag, i + 1), 32'(dut_x(i)), 32'(mx[i]));
            check($sformatf("%s.sq%0dy", tag, i + 1), 32'(dut_y(i)), 32'(my[i]));
        end
        check({tag, ".active"}, 32'(bus.active), 32'(mst == 1));
        check({tag, ".at_bottom"},
              32'({bus.at_bottom4, bus.at_bottom3, bus.at_bottom2, bus.at_bottom}), 32'(mab));
        check({tag, ".lock"}, 32'(bus.lock_pulse), 32'(mlock));
    endtask

    task automatic clear_pulses();
        bus.coord = 0; bus.drop_tick = 0; bus.move_left = 0; bus.move_right = 0;
        bus.blocked_below = '0; bus.blocked_left = '0; bus.blocked_right = '0;
`ifdef HARD_DROP_EN
        bus.hard_drop = 0;
`endif
    endtask

    initial begin
        int base_x, base_y, shp;
        Reset = 1;
        clear_pulses();
        set_spawn(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        cycle("rst0");
        cycle("rst1");
        check("rst.sq4y", 32'(bus.sq4y), 32'd0);
        check("rst.active", 32'(bus.active), 32'd0);
        Reset = 0;

        // Square piece spawn and gravity to the floor.
        set_spawn(300, 0, 320, 0, 300, 20, 320, 20);
        bus.coord = 1; cycle("spawnO"); bus.coord = 0;
        check("spawnO.sq2x", 32'(bus.sq2x), 32'd320);
        check("spawnO.sq3y", 32'(bus.sq3y), 32'd20);
        check("spawnO.active", 32'(bus.active), 32'd1);
        bus.drop_tick = 1;
        for (int k = 0; k < 22; k++) cycle("drop");
        check("drop22.sq3y", 32'(bus.sq3y), 32'd460);
        check("drop22.sq1y", 32'(bus.sq1y), 32'd440);
        cycle("landO");
        bus.drop_tick = 0;
        check("landO.ab", 32'({bus.at_bottom4, bus.at_bottom3, bus.at_bottom2, bus.at_bottom}), 32'hC);
        check("landO.lock", 32'(bus.lock_pulse), 32'd1);
        cycle("landO1");
        check("landO1.lock", 32'(bus.lock_pulse), 32'd0);

        // Vertical rod at the left wall.
        set_spawn(200, 0, 200, 20, 200, 40, 200, 60);
        bus.coord = 1; cycle("spawnI"); bus.coord = 0;
        bus.move_left = 1; cycle("wallL"); bus.move_left = 0;
        check("wallL.sq1x", 32'(bus.sq1x), 32'd200);
        bus.move_right = 1; cycle("right");
        check("right.sq4x", 32'(bus.sq4x), 32'd220);
        bus.drop_tick = 1; cycle("rightTick");
        bus.drop_tick = 0; bus.move_right = 0;
        check("rightTick.sq1y", 32'(bus.sq1y), 32'd20);
        check("rightTick.sq1x", 32'(bus.sq1x), 32'd220);
        bus.move_left = 1; bus.move_right = 1; cycle("bothMoves");
        clear_pulses();

        // Landing on board contents under square 2 only; held until the next spawn.
        bus.coord = 1; cycle("respawn"); bus.coord = 0;
        bus.drop_tick = 1; bus.blocked_below = 4'b0010; cycle("blk");
        bus.blocked_below = '0;
        check("blk.ab", 32'({bus.at_bottom4, bus.at_bottom3, bus.at_bottom2, bus.at_bottom}), 32'h2);
        bus.move_left = 1;
        for (int k = 0; k < 3; k++) cycle("held");
        clear_pulses();
        check("held.ab2", 32'(bus.at_bottom2), 32'd1);
        check("held.active", 32'(bus.active), 32'd0);
        bus.coord = 1; cycle("clr"); bus.coord = 0;
        check("clr.ab2", 32'(bus.at_bottom2), 32'd0);

        // Reset in the middle of a fall.
        bus.drop_tick = 1;
        for (int k = 0; k < 5; k++) cycle("preRst");
        bus.drop_tick = 0;
        check("preRst.sq1y", 32'(bus.sq1y), 32'd100);
        Reset = 1; cycle("midRst"); Reset = 0;
        check("midRst.sq1y", 32'(bus.sq1y), 32'd0);
        check("midRst.active", 32'(bus.active), 32'd0);

`ifdef HARD_DROP_EN
        bus.coord = 1; cycle("hdSpawn"); bus.coord = 0;
        bus.hard_drop = 1; cycle("hdLatch"); bus.hard_drop = 0;
        for (int k = 0; k < 20; k++) cycle("hdFall");
        check("hdFall.sq4y", 32'(bus.sq4y), 32'd460);
        cycle("hdLand");
        check("hdLand.ab4", 32'(bus.at_bottom4), 32'd1);
        check("hdLand.lock", 32'(bus.lock_pulse), 32'd1);
`endif

        // Random play against the model.
        for (int n = 0; n < 600; n++) begin
            clear_pulses();
            if ($urandom_range(0, 11) == 0) begin
                base_x = 200 + 20 * $urandom_range(0, 8);
                base_y = 20 * $urandom_range(0, 20);
                shp = $urandom_range(0, 2);
                case (shp)
                    0: set_spawn(base_x, base_y, base_x + 20, base_y, base_x, base_y + 20, base_x + 20, base_y + 20);
                    1: set_spawn(base_x, base_y, base_x, base_y + 20, base_x, base_y + 40, base_x, base_y + 60);
                    default: set_spawn(base_x, base_y, base_x, base_y + 20, base_x, base_y + 40, base_x + 20, base_y + 40);
                endcase
                bus.coord = 1;
            end
            bus.drop_tick  = ($urandom_range(0, 2) == 0);
            bus.move_left  = ($urandom_range(0, 2) == 0);
            bus.move_right = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) bus.blocked_below = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) bus.blocked_left  = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) bus.blocked_right = 4'($urandom_range(1, 15));
`ifdef HARD_DROP_EN
            bus.hard_drop = ($urandom_range(0, 30) == 0);
`endif
            Reset = ($urandom_range(0, 199) == 0);
            cycle("rand");
        end
        Reset = 0;
        clear_pulses();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
